// File: rtl/data_arb_pkg.sv
// Shared widths, return-tag type and requester ids for the data_ram arbiter.
package data_arb_pkg;

    localparam int DATA_ARB_ADDR_W = 17;
    localparam int DATA_ARB_DATA_W = 24;

    localparam logic [2:0] REQ_CPU    = 3'd0;
    localparam logic [2:0] REQ_DMA    = 3'd1;
    localparam logic [2:0] REQ_LOADER = 3'd2;

    typedef struct packed {
        logic       valid;
        logic [2:0] id;
    } rd_tag_t;

endpackage

// File: rtl/rr_priority_picker.sv
// One-hot grant picker: round-robin starting at ptr, or fixed lowest-index
// priority (no ptr port) when DATA_ARB_FIXED_PRIO_EN is defined.
module rr_priority_picker #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
`ifndef DATA_ARB_FIXED_PRIO_EN
    input  logic [PTR_W-1:0]   ptr,
`endif
    output logic [NUM_REQ-1:0] gnt,
    output logic [2:0]         winner
);

`ifdef DATA_ARB_FIXED_PRIO_EN

    always_comb begin
        winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[k]) winner = 3'(k);
        end
        gnt = (|req) ? (NUM_REQ'(1) << winner) : '0;
    end

`else

    logic [2*NUM_REQ-1:0] doubled;
    logic [NUM_REQ-1:0]   rotated;
    logic [2:0]           offset;
    logic [3:0]           sum;

    // Rotate so ptr sits at bit 0, take the first set bit, then rotate back.
    always_comb begin
        doubled = {req, req} >> ptr;
        rotated = doubled[NUM_REQ-1:0];
        offset  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rotated[k]) offset = 3'(k);
        end
        sum = 4'(ptr) + 4'(offset);
        if (sum >= 4'(NUM_REQ)) sum = sum - 4'(NUM_REQ);
        winner = sum[2:0];
        gnt    = (|req) ? (NUM_REQ'(1) << winner) : '0;
    end

`endif

endmodule

// File: rtl/data_ram_arbiter.sv
// Shares one data_ram port among NUM_REQ requesters with pipelined read returns.
// Define DATA_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module data_ram_arbiter
    import data_arb_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_W     = DATA_ARB_ADDR_W,
    parameter int DATA_W     = DATA_ARB_DATA_W,
    parameter int RD_LATENCY = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_address,
    input  logic [NUM_REQ*DATA_W-1:0] req_write_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      ram_rden,
    output logic                      ram_wren,
    output logic [ADDR_W-1:0]         ram_address,
    output logic [DATA_W-1:0]         ram_write_data,
    input  logic [DATA_W-1:0]         ram_read_data
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]     pick_gnt;
    logic [2:0]             winner;
    logic                   granted;
    logic                   sel_we;
    logic [ADDR_W-1:0]      sel_address;
    logic [DATA_W-1:0]      sel_write_data;
    rd_tag_t [RD_LATENCY:0] tag_pipe;
    rd_tag_t                tag_out;

`ifdef DATA_ARB_FIXED_PRIO_EN

    rr_priority_picker #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_picker (
        .req    (req),
        .gnt    (pick_gnt),
        .winner (winner)
    );

`else

    logic [PTR_W-1:0] ptr;

    rr_priority_picker #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_picker (
        .req    (req),
        .ptr    (ptr),
        .gnt    (pick_gnt),
        .winner (winner)
    );

    // The requester after the last winner gets first look next time.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (granted) begin
            ptr <= (winner == 3'(NUM_REQ - 1)) ? '0 : PTR_W'(winner + 3'd1);
        end
    end

`endif

    always_comb begin
        gnt            = reset ? '0 : pick_gnt;
        granted        = |gnt;
        sel_we         = 1'b0;
        sel_address    = '0;
        sel_write_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_we         = req_we[i];
                sel_address    = req_address[i*ADDR_W +: ADDR_W];
                sel_write_data = req_write_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Address and data hold between grants; only the enables drop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ram_rden       <= 1'b0;
            ram_wren       <= 1'b0;
            ram_address    <= '0;
            ram_write_data <= '0;
        end else if (granted) begin
            ram_rden       <= ~sel_we;
            ram_wren       <= sel_we;
            ram_address    <= sel_address;
            ram_write_data <= sel_write_data;
        end else begin
            ram_rden       <= 1'b0;
            ram_wren       <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tag_pipe <= '0;
        end else begin
            tag_pipe[0] <= rd_tag_t'{valid: granted & ~sel_we, id: winner};
            for (int s = 1; s <= RD_LATENCY; s++) begin
                tag_pipe[s] <= tag_pipe[s-1];
            end
        end
    end

    always_comb begin
        tag_out = tag_pipe[RD_LATENCY];
        rvalid  = tag_out.valid ? (NUM_REQ'(1) << tag_out.id) : '0;
    end

    assign rdata = ram_read_data;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Self-checking bench for data_ram_arbiter: directed vectors, corner sequences
// and a randomized run against a queue-based reference model.
module tb_data_ram_arbiter;

    localparam int RAND_CYCLES = 300;

    logic        clock;
    logic        reset;
    logic [2:0]  req;
    logic [2:0]  req_we;
    logic [50:0] req_address;
    logic [71:0] req_write_data;
    logic [2:0]  gnt;
    logic [2:0]  rvalid;
    logic [23:0] rdata;
    logic        ram_rden;
    logic        ram_wren;
    logic [16:0] ram_address;
    logic [23:0] ram_write_data;
    logic [23:0] ram_read_data;

    data_ram_arbiter dut (
        .clock          (clock),
        .reset          (reset),
        .req            (req),
        .req_we         (req_we),
        .req_address    (req_address),
        .req_write_data (req_write_data),
        .gnt            (gnt),
        .rvalid         (rvalid),
        .rdata          (rdata),
        .ram_rden       (ram_rden),
        .ram_wren       (ram_wren),
        .ram_address    (ram_address),
        .ram_write_data (ram_write_data),
        .ram_read_data  (ram_read_data)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    function automatic logic [23:0] init_word(input logic [16:0] a);
        return {a[7:0] ^ 8'hC3, a[16:1]};
    endfunction

    // Port A of data_ram: registered read data, one-cycle latency.
    logic [23:0] ram_mem [int];
    always @(posedge clock) begin
        if (ram_wren) ram_mem[int'(ram_address)] = ram_write_data;
        if (ram_rden) ram_read_data <= ram_mem.exists(int'(ram_address)) ?
                                       ram_mem[int'(ram_address)] : init_word(ram_address);
    end

    typedef struct {
        logic [2:0] req;
        logic [2:0] we;
        logic [2:0] exp_gnt;
        logic       exp_rden;
        logic       exp_wren;
    } vec_t;

    typedef struct {
        int          due;
        int          id;
        logic [23:0] data;
    } ret_t;

    int          checks;
    int          errors;
    vec_t        vecs [12];
    logic [16:0] cur_addr [3];
    logic [23:0] cur_data [3];
    logic [2:0]  pend;
    logic [2:0]  pwe;
    logic [23:0] ref_mem [int];
    ret_t        ret_q [$];
    int          ptr_m;
    int          win;
    logic [2:0]  exp_gnt;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [2:0] r, input logic [2:0] w);
        @(negedge clock);
        req    = r;
        req_we = w;
        for (int i = 0; i < 3; i++) begin
            req_address[i*17 +: 17]    = cur_addr[i];
            req_write_data[i*24 +: 24] = cur_data[i];
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset  = 1'b1;
        req    = '0;
        req_we = '0;
        @(negedge clock);
        reset  = 1'b0;
    endtask

    function automatic logic [23:0] model_read(input logic [16:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_word(a);
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        req = '0;
        req_we = '0;
        req_address = '0;
        req_write_data = '0;
        for (int i = 0; i < 3; i++) begin
            cur_addr[i] = 17'h200 + 17'(i);
            cur_data[i] = 24'h111111 * 24'(i + 1);
        end

        vecs[0]  = '{3'b111, 3'b000, 3'b001, 1'b0, 1'b0};
        vecs[1]  = '{3'b111, 3'b000, 3'b010, 1'b1, 1'b0};
        vecs[2]  = '{3'b111, 3'b000, 3'b100, 1'b1, 1'b0};
        vecs[3]  = '{3'b111, 3'b000, 3'b001, 1'b1, 1'b0};
        vecs[4]  = '{3'b000, 3'b000, 3'b000, 1'b1, 1'b0};
        vecs[5]  = '{3'b101, 3'b001, 3'b100, 1'b0, 1'b0};
        vecs[6]  = '{3'b101, 3'b101, 3'b001, 1'b1, 1'b0};
        vecs[7]  = '{3'b100, 3'b100, 3'b100, 1'b0, 1'b1};
        vecs[8]  = '{3'b010, 3'b000, 3'b010, 1'b0, 1'b1};
        vecs[9]  = '{3'b011, 3'b000, 3'b001, 1'b1, 1'b0};
        vecs[10] = '{3'b000, 3'b000, 3'b000, 1'b1, 1'b0};
        vecs[11] = '{3'b110, 3'b000, 3'b010, 1'b0, 1'b0};

        // Reset held with all requesters pending.
        #1 reset = 1'b1;
        req = 3'b111;
        repeat (2) begin
            @(negedge clock);
            #1;
            check_output("reset_gnt", 32'(gnt), 32'd0);
            check_output("reset_rden", 32'(ram_rden), 32'd0);
            check_output("reset_wren", 32'(ram_wren), 32'd0);
            check_output("reset_rvalid", 32'(rvalid), 32'd0);
        end
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_output("first_gnt_after_reset", 32'(gnt), 32'b001);

        do_reset();
        for (int v = 0; v < 12; v++) begin
            apply_stimulus(vecs[v].req, vecs[v].we);
            check_output($sformatf("vec%0d_gnt", v), 32'(gnt), 32'(vecs[v].exp_gnt));
            check_output($sformatf("vec%0d_rden", v), 32'(ram_rden), 32'(vecs[v].exp_rden));
            check_output($sformatf("vec%0d_wren", v), 32'(ram_wren), 32'(vecs[v].exp_wren));
        end

        // Write then read-back of the same word by requester 0.
        do_reset();
        cur_addr[0] = 17'h0000A;
        cur_data[0] = 24'hABCDEF;
        apply_stimulus(3'b001, 3'b001);
        check_output("raw_write_gnt", 32'(gnt), 32'b001);
        apply_stimulus(3'b001, 3'b000);
        check_output("raw_read_gnt", 32'(gnt), 32'b001);
        check_output("raw_wren", 32'(ram_wren), 32'd1);
        check_output("raw_address", 32'(ram_address), 32'h0000A);
        check_output("raw_write_data", 32'(ram_write_data), 32'hABCDEF);
        apply_stimulus(3'b000, 3'b000);
        check_output("raw_rden", 32'(ram_rden), 32'd1);
        check_output("raw_no_early_rvalid", 32'(rvalid), 32'd0);
        apply_stimulus(3'b000, 3'b000);
        check_output("raw_rvalid", 32'(rvalid), 32'b001);
        check_output("raw_rdata", 32'(rdata), 32'hABCDEF);

        // Single persistent requester at the top of the address space.
        do_reset();
        for (int k = 0; k < 7; k++) begin
            cur_addr[2] = 17'h1FFFF - 17'(k);
            apply_stimulus((k < 5) ? 3'b100 : 3'b000, 3'b000);
            if (k < 5) check_output($sformatf("burst%0d_gnt", k), 32'(gnt), 32'b100);
            if (k >= 2) begin
                check_output($sformatf("burst%0d_rvalid", k), 32'(rvalid), 32'b100);
                check_output($sformatf("burst%0d_rdata", k), 32'(rdata),
                             32'(init_word(17'h1FFFF - 17'(k - 2))));
            end else begin
                check_output($sformatf("burst%0d_rvalid", k), 32'(rvalid), 32'd0);
            end
        end

        // Reset lands while a granted read is in flight.
        do_reset();
        cur_addr[0] = 17'h00005;
        apply_stimulus(3'b001, 3'b000);
        check_output("inflight_gnt", 32'(gnt), 32'b001);
        @(negedge clock);
        reset = 1'b1;
        req = '0;
        #1;
        check_output("inflight_rden_cleared", 32'(ram_rden), 32'd0);
        check_output("inflight_gnt_cleared", 32'(gnt), 32'd0);
        check_output("inflight_rvalid_reset", 32'(rvalid), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_output("inflight_rvalid_dropped", 32'(rvalid), 32'd0);
        repeat (3) begin
            apply_stimulus(3'b000, 3'b000);
            check_output("inflight_rvalid_dropped", 32'(rvalid), 32'd0);
        end

        // Randomized traffic against the reference model.
        do_reset();
        pend = '0;
        pwe = '0;
        ptr_m = 0;
        ret_q.delete();
        for (int cyc = 0; cyc < RAND_CYCLES + 4; cyc++) begin
            for (int i = 0; i < 3; i++) begin
                if (!pend[i] && cyc < RAND_CYCLES && $urandom_range(0, 9) < 6) begin
                    pend[i]     = 1'b1;
                    pwe[i]      = 1'($urandom_range(0, 1));
                    cur_addr[i] = 17'h100 + 17'($urandom_range(0, 15));
                    cur_data[i] = 24'($urandom);
                end
            end
            apply_stimulus(pend, pwe);

            win = -1;
            for (int k = 0; k < 3; k++) begin
                int j;
                j = (ptr_m + k) % 3;
                if (win < 0 && pend[j]) win = j;
            end
            exp_gnt = (win < 0) ? 3'b000 : 3'(1 << win);
            check_output("rand_gnt", 32'(gnt), 32'(exp_gnt));

            if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
                check_output("rand_rvalid", 32'(rvalid), 32'(1 << ret_q[0].id));
                check_output("rand_rdata", 32'(rdata), 32'(ret_q[0].data));
                void'(ret_q.pop_front());
            end else begin
                check_output("rand_rvalid_idle", 32'(rvalid), 32'd0);
            end

            if (win >= 0) begin
                if (pwe[win]) ref_mem[int'(cur_addr[win])] = cur_data[win];
                else ret_q.push_back('{cyc + 2, win, model_read(cur_addr[win])});
                ptr_m = (win + 1) % 3;
                pend[win] = 1'b0;
            end
        end
        check_output("rand_returns_drained", 32'(ret_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
